fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter sharing one `fifo` write port between NREQ producers. Each producer presents data with a valid/ready handshake; the arbiter grants one producer at a time, steers its data onto the FIFO `din`/`we` inputs, and back-pressures all producers from the FIFO `full` flag. It sits directly in front of the `fifo` instance, and its outputs connect to that instance's `din` and `we` pins.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width; matches FIFO width.
- IDW, 2, requester-id width, ≥ clog2(NREQ).
- BURST, 4, max words per grant when ARB_BURST_EN is defined (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DW  requester i data in bits [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept; combinational.
- fifo_full  in  1  FIFO full flag.
- fifo_we  out  1  FIFO write enable; combinational.
- fifo_din  out  DW  FIFO write data; combinational mux.
- grant  out  NREQ  registered one-hot grant (all-zero when idle).
- grant_id  out  IDW  binary index of current grant (0 when idle).
- busy  out  1  high while in GRANT state.

## Operation
- States: IDLE, GRANT. Registers: grant, grant_id, rr_ptr (IDW), beat_cnt (4 bits).
- Reset values: state=IDLE, grant=0, grant_id=0, rr_ptr=0, beat_cnt=0. req_ready=0, fifo_we=0, busy=0.
- Arbitration: the winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, …, with modulo-NREQ wrap.
- IDLE: if any req_valid is high, load the winner into grant/grant_id, clear beat_cnt, go to GRANT. Otherwise stay.
- GRANT, granted index g: req_ready[g] = !fifo_full. All other bits of req_ready are 0.
- Accept = req_valid[g] & req_ready[g]. fifo_we = accept. fifo_din = req_data[g] when granted, else 0.
- On accept, beat_cnt increments.
- Release condition, evaluated each GRANT cycle:
  - req_valid[g]=0, or
  - accept with beat_cnt+1 == BURST (macro defined), or
  - accept (macro undefined).
- On release: rr_ptr = (g+1) mod NREQ. In the same edge, re-arbitrate among the current req_valid starting at g+1. The releasing requester is excluded only if req_valid[g]=0.
  - Winner found: stay in GRANT with the new grant and beat_cnt=0.
  - No winner: go to IDLE, grant=0.
- fifo_full=1 during GRANT: no accept. Grant, beat_cnt and state hold indefinitely, with no timeout. If req_valid[g] drops while full, release still occurs.
- Never writes while fifo_full=1; at most one write per cycle.
- Reset mid-burst: everything returns to reset values immediately and any word in flight that cycle is dropped (no write).

## Timing
- Arbitration latency: a request arriving in IDLE is sampled at edge N; grant is valid after edge N; first accept can occur in the cycle between edges N and N+1.
- Back-to-back grants incur no bubble; release and regrant happen in the same edge.
- Throughput: one word per cycle while not full.
- fifo_full to req_ready/fifo_we: combinational, same cycle.

## Configuration
- ARB_BURST_EN defined: a grant is held for up to BURST accepted words while req_valid[g] stays high.
- ARB_BURST_EN undefined: the grant rotates after every accepted word (strict word-level round robin). BURST is ignored and beat_cnt may be optimised away.

## Test plan
- Reset: assert rst mid-burst → grant=0, busy=0, fifo_we=0 within the same cycle; after release, req_valid=4'b0100 → grant=4'b0100 one edge later.
- Round robin, ARB_BURST_EN undefined: all four valid continuously, fifo_full=0 → fifo_we every cycle once granted, grant_id sequence 0,1,2,3,0,….
- Burst, ARB_BURST_EN defined, BURST=4: req 0 and req 2 always valid → 4 words from 0 (data 8'h10..8'h13), then 4 from 2, alternating, with no bubble cycles.
- Back-pressure: fifo_full=1 for 3 cycles during a burst → req_ready=0, fifo_we=0, grant and beat_cnt unchanged; writes resume the cycle after full drops, with a total of BURST words for that grant.
- Early release: granted requester drops valid after 2 words, another is valid → regrant at that edge, rr_ptr=g+1, no lost or duplicated words (compare against a scoreboard of 32 random words per requester).
- Single requester: only req 3 valid → repeated regrant of 3 with a continuous word stream; when req 3 drops valid → IDLE next edge.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NREQ valid/ready producers. Grant state is registered, while the
// ready/we/din path is combinational so that fifo_full acts in the same cycle.
// Optional feature: define ARB_BURST_EN to hold a grant for up to BURST
// accepted words. Without it, the grant rotates after every accepted word.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int IDW   = 2,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_din,
    output logic [NREQ-1:0]    grant,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);
`ifdef ARB_BURST_EN
    localparam logic [3:0]      LAST_BEAT = 4'(BURST - 1);
`endif

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [3:0]     beat_cnt;

    logic [IDW-1:0]  next_id;
    logic [IDW-1:0]  arb_start;
    logic [NREQ-1:0] rot_valid;
    logic            win_found;
    logic [IDW-1:0]  win_off;
    logic [IDW:0]    win_sum;
    logic [IDW-1:0]  win_id;
    logic            g_valid;
    logic            accept;
    logic            burst_done;
    logic            rel;

    assign busy = (state == GRANT);

    // Handshake toward producers and the FIFO: only the granted requester sees ready
    always_comb begin
        req_ready = (busy && !fifo_full) ? grant : '0;
        accept    = |(req_valid & req_ready);
        g_valid   = |(req_valid & grant);
        fifo_we   = accept;
        fifo_din  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                fifo_din = req_data[i*DW +: DW];
            end
        end
    end

    // Release decision for the current grant
    always_comb begin
`ifdef ARB_BURST_EN
        burst_done = accept && (beat_cnt == LAST_BEAT);
`else
        burst_done = accept;
`endif
        rel = busy && (!g_valid || burst_done);
    end

    // Round-robin search: rotate valids so the start index sits at bit 0, then take the lowest set bit
    always_comb begin
        next_id   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        arb_start = busy ? next_id : rr_ptr;
        rot_valid = NREQ'({req_valid, req_valid} >> arb_start);
        win_found = 1'b0;
        win_off   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && rot_valid[i]) begin
                win_found = 1'b1;
                win_off   = IDW'(i);
            end
        end
        win_sum = {1'b0, arb_start} + {1'b0, win_off};
        win_id  = (win_sum >= NREQ_W) ? IDW'(win_sum - NREQ_W) : win_sum[IDW-1:0];
    end

    // Arbiter FSM: grant load, burst counting, release with same-edge regrant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= GRANT;
                        grant    <= ONE_HOT << win_id;
                        grant_id <= win_id;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        rr_ptr   <= next_id;
                        beat_cnt <= '0;
                        if (win_found) begin
                            grant    <= ONE_HOT << win_id;
                            grant_id <= win_id;
                        end else begin
                            state    <= IDLE;
                            grant    <= '0;
                            grant_id <= '0;
                        end
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: hand-derived vector table, directed rotation and
// single-requester sequences, and a randomized scoreboard run checked against
// a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int IDW   = 2;
    localparam int BURST = 4;
    localparam int NWORDS = 32;
`ifdef ARB_BURST_EN
    localparam bit BURST_MODE = 1'b1;
`else
    localparam bit BURST_MODE = 1'b0;
`endif
    localparam logic [NREQ*DW-1:0] DATA = 32'hA3A2A1A0;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_we;
    logic [DW-1:0]      fifo_din;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_id;
    logic               busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_we(fifo_we),
        .fifo_din(fifo_din), .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic [IDW-1:0]  id;
        logic            busy;
        logic [NREQ-1:0] ready;
        logic            we;
        logic [DW-1:0]   din;
    } outs_t;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] v;
        logic            full;
        outs_t           exp;
    } vec_t;

    int    n_pass = 0;
    int    n_total = 0;
    outs_t got;
    outs_t exp_m;
    vec_t  vq[$];

    // reference model state
    bit m_busy;
    int m_g;
    int m_ptr;
    int m_beat;

    function automatic int pick(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (start + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o = '0;
        if (!rst && m_busy) begin
            o.grant[m_g] = 1'b1;
            o.id   = IDW'(m_g);
            o.busy = 1'b1;
            o.ready = fifo_full ? '0 : o.grant;
            o.we   = req_valid[m_g] && !fifo_full;
            o.din  = req_data[m_g*DW +: DW];
        end
        return o;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_g = 0; m_ptr = 0; m_beat = 0;
    endtask

    task automatic model_update();
        bit acc;
        bit rel;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        acc = m_busy && req_valid[m_g] && !fifo_full;
        if (!m_busy) begin
            w = pick(req_valid, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1; m_g = w; m_beat = 0;
            end
        end else begin
            rel = !req_valid[m_g] || (acc && (!BURST_MODE || (m_beat + 1 == BURST)));
            if (acc) m_beat++;
            if (rel) begin
                m_ptr = (m_g + 1) % NREQ;
                w = pick(req_valid, m_ptr);
                m_beat = 0;
                if (w >= 0) m_g = w;
                else m_busy = 1'b0;
            end
        end
    endtask

    function automatic outs_t cur_outs();
        outs_t o;
        o.grant = grant; o.id = grant_id; o.busy = busy;
        o.ready = req_ready; o.we = fifo_we; o.din = fifo_din;
        return o;
    endfunction

    function automatic outs_t mk(input logic [NREQ-1:0] g, input logic [IDW-1:0] id,
                                 input logic b, input logic [NREQ-1:0] r,
                                 input logic we, input logic [DW-1:0] din);
        outs_t o;
        o.grant = g; o.id = id; o.busy = b; o.ready = r; o.we = we; o.din = din;
        return o;
    endfunction

    task automatic add(input logic r, input logic [NREQ-1:0] v, input logic f, input outs_t e);
        vec_t t;
        t.rst = r; t.v = v; t.full = f; t.exp = e;
        vq.push_back(t);
    endtask

    task automatic cmp_outs(input string name, input outs_t g, input outs_t e);
        n_total++;
        if (g === e) n_pass++;
        else $display("FAIL %s: got grant=%b id=%0d busy=%b ready=%b we=%b din=%h, expected grant=%b id=%0d busy=%b ready=%b we=%b din=%h",
                      name, g.grant, g.id, g.busy, g.ready, g.we, g.din,
                      e.grant, e.id, e.busy, e.ready, e.we, e.din);
    endtask

    task automatic cmp_int(input string name, input int g, input int e);
        n_total++;
        if (g == e) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, g, e);
    endtask

    // apply inputs shortly after the active edge, sample outputs mid-cycle
    task automatic drive(input logic r, input logic [NREQ-1:0] v, input logic f,
                         input logic [NREQ*DW-1:0] d);
        rst = r; req_valid = v; fifo_full = f; req_data = d;
        if (r) model_reset();
        #4;
        got   = cur_outs();
        exp_m = model_outs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    logic [DW-1:0] src [NREQ][$];
    logic [DW-1:0] acc_log[$];
    logic [DW-1:0] wr_log[$];

    initial begin
        rst = 1'b1; req_valid = '0; fifo_full = 1'b0; req_data = '0;
        model_reset();
        @(posedge clk);
        #1;

        // ---------------- vector table ----------------
        add(1, 4'b1111, 0, mk(4'b0000, 0, 0, 4'b0000, 0, 8'h00));
        add(0, 4'b0000, 0, mk(4'b0000, 0, 0, 4'b0000, 0, 8'h00));
        add(0, 4'b0100, 0, mk(4'b0000, 0, 0, 4'b0000, 0, 8'h00));
        add(0, 4'b0100, 0, mk(4'b0100, 2, 1, 4'b0100, 1, 8'hA2));
        add(0, 4'b0000, 0, mk(4'b0100, 2, 1, 4'b0100, 0, 8'hA2));
        add(0, 4'b1111, 0, mk(4'b0000, 0, 0, 4'b0000, 0, 8'h00));
`ifdef ARB_BURST_EN
        add(0, 4'b1111, 0, mk(4'b1000, 3, 1, 4'b1000, 1, 8'hA3));
        add(0, 4'b1111, 1, mk(4'b1000, 3, 1, 4'b0000, 0, 8'hA3));
        add(0, 4'b1111, 0, mk(4'b1000, 3, 1, 4'b1000, 1, 8'hA3));
        add(0, 4'b1111, 0, mk(4'b1000, 3, 1, 4'b1000, 1, 8'hA3));
        add(0, 4'b1111, 0, mk(4'b1000, 3, 1, 4'b1000, 1, 8'hA3));
        add(0, 4'b0001, 0, mk(4'b0001, 0, 1, 4'b0001, 1, 8'hA0));
        add(1, 4'b0001, 0, mk(4'b0000, 0, 0, 4'b0000, 0, 8'h00));
`else
        add(0, 4'b1111, 0, mk(4'b1000, 3, 1, 4'b1000, 1, 8'hA3));
        add(0, 4'b1111, 1, mk(4'b0001, 0, 1, 4'b0000, 0, 8'hA0));
        add(0, 4'b1111, 1, mk(4'b0001, 0, 1, 4'b0000, 0, 8'hA0));
        add(0, 4'b1111, 0, mk(4'b0001, 0, 1, 4'b0001, 1, 8'hA0));
        add(0, 4'b1010, 0, mk(4'b0010, 1, 1, 4'b0010, 1, 8'hA1));
        add(0, 4'b1010, 1, mk(4'b1000, 3, 1, 4'b0000, 0, 8'hA3));
        add(0, 4'b0010, 1, mk(4'b1000, 3, 1, 4'b0000, 0, 8'hA3));
        add(1, 4'b0010, 0, mk(4'b0000, 0, 0, 4'b0000, 0, 8'h00));
`endif
        add(0, 4'b0000, 0, mk(4'b0000, 0, 0, 4'b0000, 0, 8'h00));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].v, vq[i].full, DATA);
            cmp_outs($sformatf("vec%0d", i), got, vq[i].exp);
            tick();
        end

        // ---------------- rotation sequence from idle, rr_ptr=0 ----------------
        for (int k = 0; k < 13; k++) begin
            int eid;
            drive(0, BURST_MODE ? 4'b0101 : 4'b1111, 0, DATA);
            cmp_outs("rr_model", got, exp_m);
            if (k >= 1) begin
                eid = BURST_MODE ? (((k - 1) / BURST) % 2) * 2 : (k - 1) % NREQ;
                cmp_int("rr_id", int'(grant_id), eid);
                cmp_int("rr_we", int'(fifo_we), 1);
            end
            tick();
        end
        drive(0, 4'b0000, 0, DATA);
        cmp_outs("rr_drop", got, exp_m);
        tick();

        // ---------------- single requester ----------------
        for (int k = 0; k < 7; k++) begin
            drive(0, 4'b1000, 0, DATA);
            cmp_outs("single_model", got, exp_m);
            if (k == 0) cmp_int("single_wait", int'(busy), 0);
            else begin
                cmp_int("single_id", int'(grant_id), 3);
                cmp_int("single_we", int'(fifo_we), 1);
            end
            tick();
        end
        drive(0, 4'b0000, 0, DATA);
        cmp_outs("single_drop", got, exp_m);
        tick();
        drive(0, 4'b0000, 0, DATA);
        cmp_int("single_idle", int'(busy), 0);
        tick();

        // ---------------- randomized scoreboard run ----------------
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < NWORDS; j++)
                src[i].push_back(DW'($urandom));
        for (int c = 0; c < 3000; c++) begin
            logic [NREQ-1:0]    v;
            logic [NREQ*DW-1:0] d;
            int left;
            left = 0;
            for (int i = 0; i < NREQ; i++) left += src[i].size();
            if (left == 0) break;
            v = '0; d = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (src[i].size() > 0) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    d[i*DW +: DW] = src[i][0];
                end else begin
                    d[i*DW +: DW] = DW'($urandom);
                end
            end
            drive(0, v, ($urandom_range(0, 4) == 0), d);
            cmp_outs("rand_model", got, exp_m);
            if (exp_m.we) acc_log.push_back(src[m_g].pop_front());
            if (fifo_we) wr_log.push_back(fifo_din);
            tick();
        end
        begin
            int left;
            left = 0;
            for (int i = 0; i < NREQ; i++) left += src[i].size();
            cmp_int("rand_drained", left, 0);
        end
        cmp_int("rand_wr_count", wr_log.size(), NREQ * NWORDS);
        for (int i = 0; i < acc_log.size() && i < wr_log.size(); i++)
            cmp_int($sformatf("rand_word%0d", i), int'(wr_log[i]), int'(acc_log[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
